// File: rtl/wimax_qpsk_demapper_if.sv
// Symbol-in / bit-out stream bundle for the WiMAX QPSK demapper.
// erasure_out is present only when WIMAX_DEMAP_ERASURE_EN is defined.
interface wimax_qpsk_demapper_if #(
    parameter int DATA_W = 16
);
    logic signed [DATA_W-1:0] I_comp;
    logic signed [DATA_W-1:0] Q_comp;
    logic                     valid_in;
    logic                     ready_out;
    logic                     data_out;
    logic                     valid_out;
    logic                     ready_in;
    logic                     last_out;
    logic [15:0]              frame_count;
`ifdef WIMAX_DEMAP_ERASURE_EN
    logic                     erasure_out;
`endif

    modport master (
        output I_comp, Q_comp, valid_in, ready_in,
        input  ready_out, data_out, valid_out, last_out, frame_count
`ifdef WIMAX_DEMAP_ERASURE_EN
        , input erasure_out
`endif
    );

    modport slave (
        input  I_comp, Q_comp, valid_in, ready_in,
        output ready_out, data_out, valid_out, last_out, frame_count
`ifdef WIMAX_DEMAP_ERASURE_EN
        , output erasure_out
`endif
    );
endinterface

// File: rtl/wimax_qpsk_demapper.sv
// Hard-decision QPSK demapper: slices I/Q sign bits and serializes them (I first) with frame markers.
// Optional erasure flagging is enabled by defining WIMAX_DEMAP_ERASURE_EN.
module wimax_qpsk_demapper #(
    parameter int DATA_W     = 16,
    parameter int FRAME_BITS = 192
`ifdef WIMAX_DEMAP_ERASURE_EN
    , parameter logic signed [DATA_W-1:0] ERASE_THRESH = 16'sd2048
`endif
) (
    input  logic                  clk_100,
    input  logic                  reset_N,
    wimax_qpsk_demapper_if.slave  bus
);
    localparam int CNT_W = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_BITS - 1);

    typedef enum logic [1:0] {IDLE, SEND_I, SEND_Q} state_e;

    state_e           state_q, state_d;
    logic             bit_i_q, bit_i_d;
    logic             bit_q_q, bit_q_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [15:0]      frame_cnt_q, frame_cnt_d;

    logic ready_o, valid_o, data_o, last_o;
    logic accept, fire;

`ifdef WIMAX_DEMAP_ERASURE_EN
    logic era_i_q, era_i_d;
    logic era_q_q, era_q_d;
    logic erasure_o;

    // Saturating magnitude: the most negative code counts as full scale.
    function automatic logic below_thresh(input logic signed [DATA_W-1:0] x);
        logic signed [DATA_W-1:0] mag;
        if (x == {1'b1, {(DATA_W-1){1'b0}}}) mag = {1'b0, {(DATA_W-1){1'b1}}};
        else if (x[DATA_W-1])                mag = -x;
        else                                 mag = x;
        return mag < ERASE_THRESH;
    endfunction
`endif

    always_ff @(posedge clk_100) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (!reset_N) begin
            state_q     <= IDLE;
            bit_i_q     <= 1'b0;
            bit_q_q     <= 1'b0;
            cnt_q       <= '0;
            frame_cnt_q <= '0;
`ifdef WIMAX_DEMAP_ERASURE_EN
            era_i_q     <= 1'b0;
            era_q_q     <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            bit_i_q     <= bit_i_d;
            bit_q_q     <= bit_q_d;
            cnt_q       <= cnt_d;
            frame_cnt_q <= frame_cnt_d;
`ifdef WIMAX_DEMAP_ERASURE_EN
            era_i_q     <= era_i_d;
            era_q_q     <= era_q_d;
`endif
        end
    end

    always_comb begin
        // NOTE: defaults first so no path leaves a signal unassigned (no latches).
        state_d     = state_q;
        bit_i_d     = bit_i_q;
        bit_q_d     = bit_q_q;
        cnt_d       = cnt_q;
        frame_cnt_d = frame_cnt_q;
        accept      = bus.valid_in && ready_o;
        fire        = valid_o && bus.ready_in;
`ifdef WIMAX_DEMAP_ERASURE_EN
        era_i_d     = era_i_q;
        era_q_d     = era_q_q;
`endif
        case (state_q)
            IDLE:    if (accept)      state_d = SEND_I;
            SEND_I:  if (bus.ready_in) state_d = SEND_Q;
            SEND_Q:  if (bus.ready_in) state_d = accept ? SEND_I : IDLE;
            default: state_d = IDLE;
        endcase
        if (accept) begin
            bit_i_d = bus.I_comp[DATA_W-1];
            bit_q_d = bus.Q_comp[DATA_W-1];
`ifdef WIMAX_DEMAP_ERASURE_EN
            era_i_d = below_thresh(bus.I_comp);
            era_q_d = below_thresh(bus.Q_comp);
`endif
        end
        if (fire) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d       = '0;
                frame_cnt_d = frame_cnt_q + 16'd1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        ready_o = 1'b0;
        valid_o = 1'b0;
        data_o  = 1'b0;
`ifdef WIMAX_DEMAP_ERASURE_EN
        erasure_o = 1'b0;
`endif
        case (state_q)
            IDLE:   ready_o = 1'b1;
            SEND_I: begin
                valid_o = 1'b1;
                data_o  = bit_i_q;
`ifdef WIMAX_DEMAP_ERASURE_EN
                erasure_o = era_i_q;
`endif
            end
            SEND_Q: begin
                valid_o = 1'b1;
                data_o  = bit_q_q;
                ready_o = bus.ready_in;
`ifdef WIMAX_DEMAP_ERASURE_EN
                erasure_o = era_q_q;
`endif
            end
            default: ;
        endcase
        last_o = valid_o && (cnt_q == CNT_LAST);
    end

    assign bus.ready_out   = ready_o;
    assign bus.valid_out   = valid_o;
    assign bus.data_out    = data_o;
    assign bus.last_out    = last_o;
    assign bus.frame_count = frame_cnt_q;
`ifdef WIMAX_DEMAP_ERASURE_EN
    assign bus.erasure_out = erasure_o;
`endif
endmodule

// File: tb/tb_wimax_qpsk_demapper.sv
// Directed bench for wimax_qpsk_demapper; erasure steps run when WIMAX_DEMAP_ERASURE_EN is defined.
module tb_wimax_qpsk_demapper;
    logic clk = 1'b0;
    logic reset_N = 1'b0;
    int   checks = 0;
    int   errors = 0;

    logic [191:0] ref_vec = 192'hC3A5_96F0_1E7D_4B28_E1D0_5A3C_7F08_9B64_2DE6_A51C_3087_F94E;

    always #5 clk = ~clk;

    wimax_qpsk_demapper_if #(.DATA_W(16)) bus ();

    wimax_qpsk_demapper #(.DATA_W(16), .FRAME_BITS(192)) dut (
        .clk_100 (clk),
        .reset_N (reset_N),
        .bus     (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Modulator model: sign carries the bit, magnitude varies with position.
    function automatic logic signed [15:0] comp(input logic b, input int k);
        case (k % 4)
            0:       return b ? -16'sd1    : 16'sd0;
            1:       return b ? -16'sd5793 : 16'sd100;
            2:       return b ? 16'sh8000  : 16'sd5793;
            default: return b ? -16'sd2048 : 16'sd32767;
        endcase
    endfunction

    task automatic stream(input int n_sym);
        int  idx = 0;
        int  pos = 0;
        int  gaps = 0;
        bit  started = 0;
        bit  acc;
        bus.ready_in = 1'b1;
        for (int cyc = 0; cyc < 4 * n_sym + 20 && pos < 2 * n_sym; cyc++) begin
            bus.valid_in = (idx < n_sym);
            if (idx < n_sym) begin
                bus.I_comp = comp(ref_vec[2*idx], 2*idx);
                bus.Q_comp = comp(ref_vec[2*idx+1], 2*idx+1);
            end
            #1;
            acc = bus.valid_in && bus.ready_out;
            if (bus.valid_out) begin
                started = 1;
                check($sformatf("stream_bit%0d", pos), bus.data_out, ref_vec[pos]);
                check($sformatf("stream_last%0d", pos), bus.last_out, (pos == 191));
                pos++;
            end else if (started) begin
                gaps++;
            end
            tick();
            if (acc) idx++;
        end
        bus.valid_in = 1'b0;
        check("stream_len", pos, 2 * n_sym);
        check("stream_gaps", gaps, 0);
    endtask

    initial begin
        bus.valid_in = 1'b1;
        bus.ready_in = 1'b1;
        bus.I_comp   = 16'sh8000;
        bus.Q_comp   = 16'sh8000;
        reset_N      = 1'b0;

        // Reset held three cycles with valid_in asserted.
        repeat (3) tick();
        check("rst_valid_during", bus.valid_out, 1'b0);
        reset_N      = 1'b1;
        bus.valid_in = 1'b0;
        #1;
        check("rst_ready", bus.ready_out, 1'b1);
        check("rst_valid", bus.valid_out, 1'b0);
        check("rst_data", bus.data_out, 1'b0);
        check("rst_last", bus.last_out, 1'b0);
        check("rst_fc", bus.frame_count, 16'd0);
        tick();

        // Single symbol: I negative, Q positive.
        bus.I_comp   = 16'shA57E;
        bus.Q_comp   = 16'sh5A82;
        bus.valid_in = 1'b1;
        #1;
        check("single_ready_idle", bus.ready_out, 1'b1);
        tick();
        bus.valid_in = 1'b0;
        #1;
        check("single_i_valid", bus.valid_out, 1'b1);
        check("single_i_data", bus.data_out, 1'b1);
        check("single_i_ready", bus.ready_out, 1'b0);
        tick();
        #1;
        check("single_q_valid", bus.valid_out, 1'b1);
        check("single_q_data", bus.data_out, 1'b0);
        tick();
        #1;
        check("single_idle_valid", bus.valid_out, 1'b0);

        // Clean frame alignment, then one full frame back-to-back.
        reset_N = 1'b0;
        tick();
        reset_N = 1'b1;
        stream(96);
        check("frame1_fc", bus.frame_count, 16'd1);

        // 50 bits into a frame, then reset with a symbol held.
        stream(25);
        bus.I_comp   = -16'sd300;
        bus.Q_comp   = 16'sd300;
        bus.valid_in = 1'b1;
        tick();
        bus.valid_in = 1'b0;
        reset_N      = 1'b0;
        #1;
        check("midrst_pre_valid", bus.valid_out, 1'b1);
        tick();
        check("midrst_valid", bus.valid_out, 1'b0);
        check("midrst_fc", bus.frame_count, 16'd0);
        check("midrst_ready", bus.ready_out, 1'b1);
        reset_N = 1'b1;
        stream(96);
        check("midrst_frame_fc", bus.frame_count, 16'd1);

        // Backpressure in SEND_Q with the next symbol waiting upstream.
        bus.I_comp   = -16'sd5793;
        bus.Q_comp   = 16'sd100;
        bus.valid_in = 1'b1;
        bus.ready_in = 1'b1;
        tick();
        bus.I_comp = -16'sd100;
        bus.Q_comp = 16'sd0;
        #1;
        check("bp_i_data", bus.data_out, 1'b1);
        check("bp_i_ready", bus.ready_out, 1'b0);
        tick();
        bus.ready_in = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            check($sformatf("bp_hold_valid%0d", i), bus.valid_out, 1'b1);
            check($sformatf("bp_hold_data%0d", i), bus.data_out, 1'b0);
            check($sformatf("bp_hold_ready%0d", i), bus.ready_out, 1'b0);
            check($sformatf("bp_hold_last%0d", i), bus.last_out, 1'b0);
            tick();
        end
        bus.ready_in = 1'b1;
        #1;
        check("bp_resume_ready", bus.ready_out, 1'b1);
        tick();
        bus.valid_in = 1'b0;
        #1;
        check("bp_next_i_valid", bus.valid_out, 1'b1);
        check("bp_next_i_data", bus.data_out, 1'b1);
        tick();
        #1;
        check("bp_next_q_valid", bus.valid_out, 1'b1);
        check("bp_next_q_data", bus.data_out, 1'b0);
        tick();
        #1;
        check("bp_idle", bus.valid_out, 1'b0);
        check("bp_fc", bus.frame_count, 16'd1);

`ifdef WIMAX_DEMAP_ERASURE_EN
        tick();
        bus.I_comp   = 16'sd100;
        bus.Q_comp   = -16'sd5793;
        bus.valid_in = 1'b1;
        tick();
        bus.valid_in = 1'b0;
        #1;
        check("era1_i_flag", bus.erasure_out, 1'b1);
        check("era1_i_data", bus.data_out, 1'b0);
        tick();
        #1;
        check("era1_q_flag", bus.erasure_out, 1'b0);
        check("era1_q_data", bus.data_out, 1'b1);
        tick();
        bus.I_comp   = 16'sh8000;
        bus.Q_comp   = 16'sd0;
        bus.valid_in = 1'b1;
        tick();
        bus.valid_in = 1'b0;
        #1;
        check("era2_i_flag", bus.erasure_out, 1'b0);
        check("era2_i_data", bus.data_out, 1'b1);
        tick();
        #1;
        check("era2_q_flag", bus.erasure_out, 1'b1);
        check("era2_q_data", bus.data_out, 1'b0);
        tick();
        #1;
        check("era_idle_flag", bus.erasure_out, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
